ram16x4_ctrl: RTL and testbench

//  Access controller for the 16x4 register-file RAM built from 4-bit parallel registers.

---
 rtl/ram16x4_ctrl.sv | 166 ++++++++++++++++
 tb/tb_ram16x4_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram16x4_ctrl.sv
// ram16x4_ctrl: access controller for a 16x4 register-file RAM built from
// 4-bit parallel registers. Two requesters (A, B) share one RAM port under a
// round-robin arbiter. After reset an optional clear sequence writes INIT_VAL
// to every word before any access is accepted.
module ram16x4_ctrl #(
  parameter int unsigned   DW             = 4,
  parameter int unsigned   AW             = 4,
  parameter logic [DW-1:0] INIT_VAL       = '0,
  parameter bit            CLEAR_ON_RESET = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  // requester A
  input  logic               req_a,
  input  logic               we_a,
  input  logic [AW-1:0]      addr_a,
  input  logic [DW-1:0]      wdata_a,
  output logic               ack_a,
  output logic [DW-1:0]      rdata_a,
  // requester B
  input  logic               req_b,
  input  logic               we_b,
  input  logic [AW-1:0]      addr_b,
  input  logic [DW-1:0]      wdata_b,
  output logic               ack_b,
  output logic [DW-1:0]      rdata_b,
  // RAM port
  output logic [2**AW-1:0]   ram_en,
  output logic [DW-1:0]      ram_din,
  output logic [AW-1:0]      ram_sel,
  input  logic [DW-1:0]      ram_q,
  output logic               busy
);

  localparam int unsigned DEPTH = 2**AW;
  localparam logic [DEPTH-1:0] EN_ONE = DEPTH'(1);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [AW-1:0]   cnt;         // clear-sequence word pointer
  logic            last_b;      // 1: most recent grant went to B
  logic            grant_b;     // arbitration result while in IDLE
  logic            any_req;

  // latched request of the access in flight
  logic            id_b;
  logic            we_l;
  logic [AW-1:0]   addr_l;
  logic [DW-1:0]   wdata_l;

  // last values driven on the shared buses, held while the port is idle
  logic [DW-1:0]   din_hold;
  logic [AW-1:0]   sel_hold;

  assign any_req = req_a | req_b;
  // B wins when it is the only requester, or on a tie when A was served last.
  assign grant_b = req_b & (~req_a | ~last_b);

  // State register: reset restarts the clear sequence (or goes straight to IDLE).
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create order-dependent races.
    if (reset) begin
      state <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path through the case leaves state_next
    // unassigned, which would otherwise infer a latch.
    state_next = state;
    unique case (state)
      S_CLEAR:  if (&cnt) state_next = S_IDLE;
      S_IDLE:   if (any_req) state_next = S_ACCESS;
      S_ACCESS: state_next = S_RESP;
      S_RESP:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Datapath: clear counter, arbitration history, request latch, read capture, acks.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the latch and hold registers are reset as well so the RAM buses
      // never show X, even when the clear sequence is disabled.
      cnt      <= '0;
      last_b   <= 1'b1;
      ack_a    <= 1'b0;
      ack_b    <= 1'b0;
      rdata_a  <= '0;
      rdata_b  <= '0;
      id_b     <= 1'b0;
      we_l     <= 1'b0;
      addr_l   <= '0;
      wdata_l  <= '0;
      din_hold <= '0;
      sel_hold <= '0;
    end else begin
      // acks are high exactly during the RESP cycle that follows ACCESS
      ack_a <= (state == S_ACCESS) & ~id_b;
      ack_b <= (state == S_ACCESS) &  id_b;

      unique case (state)
        S_CLEAR: begin
          cnt      <= cnt + AW'(1);  // wraps to 0 on the last clear cycle
          din_hold <= INIT_VAL;
        end
        S_IDLE: begin
          if (any_req) begin
            id_b    <= grant_b;
            last_b  <= grant_b;
            we_l    <= grant_b ? we_b    : we_a;
            addr_l  <= grant_b ? addr_b  : addr_a;
            wdata_l <= grant_b ? wdata_b : wdata_a;
          end
        end
        S_ACCESS: begin
          if (we_l) begin
            din_hold <= wdata_l;
          end else begin
            sel_hold <= addr_l;
            if (id_b) rdata_b <= ram_q;
            else      rdata_a <= ram_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Moore outputs decoded from the registered state and request latch.
  always_comb begin
    ram_en  = '0;
    ram_din = din_hold;
    ram_sel = sel_hold;
    busy    = 1'b0;
    unique case (state)
      S_CLEAR: begin
        busy    = 1'b1;
        ram_en  = EN_ONE << cnt;
        ram_din = INIT_VAL;
      end
      S_ACCESS: begin
        if (we_l) begin
          ram_en  = EN_ONE << addr_l;
          ram_din = wdata_l;
        end else begin
          ram_sel = addr_l;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ram16x4_ctrl.sv
// tb_ram16x4_ctrl: directed bench for ram16x4_ctrl. A behavioural 16x4
// register-file RAM sits on the controller's RAM port.
module tb_ram16x4_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_a = 1'b0, we_a = 1'b0;
  logic [3:0]  addr_a = '0, wdata_a = '0;
  logic        ack_a;
  logic [3:0]  rdata_a;
  logic        req_b = 1'b0, we_b = 1'b0;
  logic [3:0]  addr_b = '0, wdata_b = '0;
  logic        ack_b;
  logic [3:0]  rdata_b;
  logic [15:0] ram_en;
  logic [3:0]  ram_din;
  logic [3:0]  ram_sel;
  logic [3:0]  ram_q;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int onehot_err = 0;
  bit mon_en = 1'b0;

  ram16x4_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .req_a   (req_a),
    .we_a    (we_a),
    .addr_a  (addr_a),
    .wdata_a (wdata_a),
    .ack_a   (ack_a),
    .rdata_a (rdata_a),
    .req_b   (req_b),
    .we_b    (we_b),
    .addr_b  (addr_b),
    .wdata_b (wdata_b),
    .ack_b   (ack_b),
    .rdata_b (rdata_b),
    .ram_en  (ram_en),
    .ram_din (ram_din),
    .ram_sel (ram_sel),
    .ram_q   (ram_q),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Register-file RAM: each word loads ram_din when its enable is high.
  logic [3:0] mem [16];
  always @(posedge clk) begin
    for (int i = 0; i < 16; i++) begin
      if (ram_en[i]) mem[i] <= ram_din;
    end
  end
  assign ram_q = mem[ram_sel];

  // Count any cycle with more than one word enabled.
  always @(negedge clk) begin
    if (mon_en && $countones(ram_en) > 1) onehot_err++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reset for one edge; returns in CLEAR cycle 0.
  task automatic apply_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // One handshake for requester A (b=0) or B (b=1), starting in an IDLE cycle.
  // lat = cycles from raising req to seeing ack; returns in the following IDLE.
  task automatic access(input bit b, input bit we, input logic [3:0] addr,
                        input logic [3:0] wd, output bit acked,
                        output logic [3:0] rd, output int lat);
    acked = 1'b0;
    rd    = '0;
    lat   = 0;
    if (b) begin req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wd; end
    else   begin req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wd; end
    for (int c = 0; c < 20 && !acked; c++) begin
      tick();
      lat++;
      if (b ? ack_b : ack_a) begin
        acked = 1'b1;
        rd    = b ? rdata_b : rdata_a;
      end
    end
    req_a = 1'b0;
    req_b = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    reset  = 1'b0;
    mon_en = 1'b1;
    checks++;
    if ({ack_a, ack_b, rdata_a, rdata_b} !== 10'h000) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=000", {ack_a, ack_b, rdata_a, rdata_b});
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (busy !== 1'b1 || ram_en !== (16'h0001 << i) || ram_din !== 4'h0) begin
        failures++;
        $display("FAIL clear_cycle%0d got busy=%b en=%h din=%h exp busy=1 en=%h din=0",
                 i, busy, ram_en, ram_din, 16'h0001 << i);
      end
      tick();
    end
    checks++;
    if (busy !== 1'b0 || ram_en !== 16'h0000) begin
      failures++;
      $display("FAIL clear_done got busy=%b en=%h exp busy=0 en=0000", busy, ram_en);
    end
  endtask

  task automatic test_write_read;
    req_a = 1'b1; we_a = 1'b1; addr_a = 4'd5; wdata_a = 4'hA;
    checks++;
    if (ram_en !== 16'h0000) begin
      failures++;
      $display("FAIL wr_idle_en got=%h exp=0000", ram_en);
    end
    tick();
    checks++;
    if (ram_en !== 16'h0020 || ram_din !== 4'hA || ack_a !== 1'b0) begin
      failures++;
      $display("FAIL wr_access got en=%h din=%h ack=%b exp en=0020 din=a ack=0",
               ram_en, ram_din, ack_a);
    end
    tick();
    checks++;
    if (ack_a !== 1'b1 || ram_en !== 16'h0000) begin
      failures++;
      $display("FAIL wr_ack got ack=%b en=%h exp ack=1 en=0000", ack_a, ram_en);
    end
    req_a = 1'b0;
    tick();
    checks++;
    if (ack_a !== 1'b0) begin
      failures++;
      $display("FAIL wr_ack_pulse got=%b exp=0", ack_a);
    end
    req_b = 1'b1; we_b = 1'b0; addr_b = 4'd5;
    tick();
    checks++;
    if (ram_sel !== 4'd5 || ram_en !== 16'h0000) begin
      failures++;
      $display("FAIL rd_access got sel=%h en=%h exp sel=5 en=0000", ram_sel, ram_en);
    end
    tick();
    checks++;
    if (ack_b !== 1'b1 || rdata_b !== 4'hA || ack_a !== 1'b0) begin
      failures++;
      $display("FAIL rd_ack got ack_b=%b rdata_b=%h ack_a=%b exp 1 a 0", ack_b, rdata_b, ack_a);
    end
    req_b = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back;
    int n;
    bit who [4];
    int when [4];
    n = 0;
    apply_reset();
    repeat (16) tick();
    req_a = 1'b1; we_a = 1'b1; addr_a = 4'd1; wdata_a = 4'h3;
    req_b = 1'b1; we_b = 1'b1; addr_b = 4'd2; wdata_b = 4'h4;
    for (int c = 1; c <= 16 && n < 4; c++) begin
      tick();
      if (ack_a && ack_b) begin
        checks++;
        failures++;
        $display("FAIL tie_both_ack cycle=%0d got both exp one", c);
      end else if (ack_a || ack_b) begin
        who[n]  = ack_b;
        when[n] = c;
        n++;
      end
    end
    req_a = 1'b0;
    req_b = 1'b0;
    tick();
    checks++;
    if (n !== 4) begin
      failures++;
      $display("FAIL tie_ack_count got=%0d exp=4", n);
    end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (who[k] !== k[0] || when[k] !== 2 + 3 * k) begin
        failures++;
        $display("FAIL tie_ack%0d got who=%0d cycle=%0d exp who=%0d cycle=%0d",
                 k, who[k], when[k], k % 2, 2 + 3 * k);
      end
    end
    checks++;
    if (mem[1] !== 4'h3 || mem[2] !== 4'h4) begin
      failures++;
      $display("FAIL tie_mem got m1=%h m2=%h exp 3 4", mem[1], mem[2]);
    end
  endtask

  task automatic test_req_during_clear;
    apply_reset();
    repeat (3) tick();
    req_a = 1'b1; we_a = 1'b1; addr_a = 4'd7; wdata_a = 4'h9;
    for (int i = 3; i < 16; i++) begin
      checks++;
      if (ack_a !== 1'b0 || ram_en !== (16'h0001 << i)) begin
        failures++;
        $display("FAIL clr_req_cycle%0d got ack=%b en=%h exp ack=0 en=%h",
                 i, ack_a, ram_en, 16'h0001 << i);
      end
      tick();
    end
    checks++;
    if (busy !== 1'b0 || ram_en !== 16'h0000) begin
      failures++;
      $display("FAIL clr_req_idle got busy=%b en=%h exp 0 0000", busy, ram_en);
    end
    tick();
    checks++;
    if (ram_en !== 16'h0080 || ram_din !== 4'h9) begin
      failures++;
      $display("FAIL clr_req_access got en=%h din=%h exp en=0080 din=9", ram_en, ram_din);
    end
    tick();
    checks++;
    if (ack_a !== 1'b1) begin
      failures++;
      $display("FAIL clr_req_ack got=%b exp=1", ack_a);
    end
    req_a = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_access;
    bit seen;
    bit ok;
    logic [3:0] rd;
    int lat;
    seen = 1'b0;
    req_a = 1'b1; we_a = 1'b1; addr_a = 4'd2; wdata_a = 4'h7;
    tick();
    checks++;
    if (ram_en !== 16'h0004) begin
      failures++;
      $display("FAIL rst_acc_en got=%h exp=0004", ram_en);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_a = 1'b0;
    checks++;
    if (ack_a !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_acc_after got ack=%b busy=%b exp ack=0 busy=1", ack_a, busy);
    end
    repeat (16) begin
      if (ack_a) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_acc_clear got ack_seen=%b busy=%b exp 0 0", seen, busy);
    end
    access(1'b0, 1'b0, 4'd2, 4'h0, ok, rd, lat);
    checks++;
    if (!ok || rd !== 4'h0) begin
      failures++;
      $display("FAIL rst_acc_read2 got ack=%b rdata=%h exp ack=1 rdata=0", ok, rd);
    end
  endtask

  task automatic test_boundary;
    bit ok;
    logic [3:0] rd;
    int lat;
    access(1'b0, 1'b1, 4'd15, 4'hF, ok, rd, lat);
    checks++;
    if (!ok || lat !== 2) begin
      failures++;
      $display("FAIL bnd_write15 got ack=%b lat=%0d exp ack=1 lat=2", ok, lat);
    end
    access(1'b1, 1'b0, 4'd0, 4'h0, ok, rd, lat);
    checks++;
    if (!ok || lat !== 2 || rd !== 4'h0) begin
      failures++;
      $display("FAIL bnd_read0 got ack=%b lat=%0d rdata=%h exp 1 2 0", ok, lat, rd);
    end
    access(1'b0, 1'b0, 4'd15, 4'h0, ok, rd, lat);
    checks++;
    if (!ok || lat !== 2 || rd !== 4'hF) begin
      failures++;
      $display("FAIL bnd_read15 got ack=%b lat=%0d rdata=%h exp 1 2 f", ok, lat, rd);
    end
  endtask

  task automatic test_onehot;
    checks++;
    if (onehot_err !== 0) begin
      failures++;
      $display("FAIL ram_en_onehot got=%0d multi-hot cycles exp=0", onehot_err);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_req_during_clear();
    test_reset_in_access();
    test_boundary();
    test_onehot();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
